// File: rtl/rob_param_pkg.sv
// -----------------------------------------------------------------------------
// rob_param_pkg
// Shared types for the reorder buffer and its neighbours:
//   op_t        - instruction class carried through the ROB to commit
//   rob_state_t - ROB control state (normal operation / one-cycle squash)
// The entry record (op + destination register) is declared inside rob_param
// because its register-index width follows that module's RD_W parameter.
// -----------------------------------------------------------------------------
package rob_param_pkg;

    typedef enum logic [1:0] {
        OP_ALU    = 2'd0,
        OP_LD     = 2'd1,
        OP_ST     = 2'd2,
        OP_BRANCH = 2'd3
    } op_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } rob_state_t;

    localparam int ROB_DEPTH_DEF     = 8;
    localparam int ROB_CDB_PORTS_DEF = 2;
    localparam int ROB_RD_W_DEF      = 5;

endpackage

// File: rtl/rob_param_if.sv
// -----------------------------------------------------------------------------
// rob_param_if
// Bundles every reorder-buffer connection except clock and reset.
//   dispatch : disp_valid/disp_ready/disp_op/disp_rd/disp_tag
//   complete : cdb_valid/cdb_tag (CDB_PORTS strobes, packed tags)
//   resolve  : br_valid/br_tag/br_mispredict
//   commit   : commit_valid/commit_ready/commit_op/commit_rd/commit_tag
//   status   : flush/flush_mask/ld_pc/rob_empty/entry_done
// Modports:
//   master - the surrounding core (IQ, RS/CDB, branch unit, commit consumer)
//   slave  - the ROB itself
// -----------------------------------------------------------------------------
interface rob_param_if #(
    parameter int DEPTH     = 8,
    parameter int CDB_PORTS = 2,
    parameter int RD_W      = 5
);
    import rob_param_pkg::*;

    localparam int TAG_W = $clog2(DEPTH);

    logic                         disp_valid;
    logic                         disp_ready;
    op_t                          disp_op;
    logic [RD_W-1:0]              disp_rd;
    logic [TAG_W-1:0]             disp_tag;

    logic [CDB_PORTS-1:0]         cdb_valid;
    logic [CDB_PORTS*TAG_W-1:0]   cdb_tag;

    logic                         br_valid;
    logic [TAG_W-1:0]             br_tag;
    logic                         br_mispredict;

    logic                         commit_valid;
    logic                         commit_ready;
    op_t                          commit_op;
    logic [RD_W-1:0]              commit_rd;
    logic [TAG_W-1:0]             commit_tag;

    logic                         flush;
    logic [DEPTH-1:0]             flush_mask;
    logic                         ld_pc;
    logic                         rob_empty;
    logic [DEPTH-1:0]             entry_done;

    modport master (
        output disp_valid, disp_op, disp_rd,
        output cdb_valid, cdb_tag,
        output br_valid, br_tag, br_mispredict,
        output commit_ready,
        input  disp_ready, disp_tag,
        input  commit_valid, commit_op, commit_rd, commit_tag,
        input  flush, flush_mask, ld_pc, rob_empty, entry_done
    );

    modport slave (
        input  disp_valid, disp_op, disp_rd,
        input  cdb_valid, cdb_tag,
        input  br_valid, br_tag, br_mispredict,
        input  commit_ready,
        output disp_ready, disp_tag,
        output commit_valid, commit_op, commit_rd, commit_tag,
        output flush, flush_mask, ld_pc, rob_empty, entry_done
    );

endinterface

// File: rtl/rob_param_age_mask.sv
// -----------------------------------------------------------------------------
// rob_age_mask
// Combinational age comparator for a circular buffer.
//   head   in  TAG_W  oldest entry index
//   br_tag in  TAG_W  reference entry index
//   mask   out DEPTH  bit x set when entry x is strictly younger than br_tag,
//                     i.e. (x-head) mod DEPTH > (br_tag-head) mod DEPTH
// The mask is not qualified by allocation; callers AND it with their own
// valid vector. Shared with the LSQ for load/store ordering checks.
// -----------------------------------------------------------------------------
module rob_age_mask #(
    parameter int DEPTH = 8,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic [TAG_W-1:0] head,
    input  logic [TAG_W-1:0] br_tag,
    output logic [DEPTH-1:0] mask
);

    logic [TAG_W-1:0] br_age_s;
    logic [TAG_W-1:0] x_age_s;

    // Per-entry age relative to head, compared against the reference age
    always_comb begin
        mask     = '0;
        x_age_s  = '0;
        // Modular subtraction: TAG_W-bit wrap gives the distance from head
        br_age_s = br_tag - head;
        for (int i = 0; i < DEPTH; i++) begin
            x_age_s = TAG_W'(i) - head;
            mask[i] = (x_age_s > br_age_s);
        end
    end

endmodule

// File: rtl/rob_param.sv
// -----------------------------------------------------------------------------
// rob_param
// Parametrised reorder buffer for the Tomasulo core.
//   clk  in  clock
//   rst  in  synchronous reset, active-low
//   bus  rob_param_if.slave:
//     dispatch from the IQ allocates entry[tail] and returns disp_tag=tail;
//     CDB ports mark entries done; the branch unit resolves branches and on a
//     mispredict squashes every younger entry in one cycle (flush_mask tells
//     the regfile which tags to repair, flush/ld_pc pulse for one cycle);
//     commit presents the head entry once it is allocated and done.
// Occupancy is tracked by a TAG_W+1 bit counter so all DEPTH slots are usable.
// -----------------------------------------------------------------------------
module rob_param
    import rob_param_pkg::*;
#(
    parameter int DEPTH     = ROB_DEPTH_DEF,
    parameter int CDB_PORTS = ROB_CDB_PORTS_DEF,
    parameter int RD_W      = ROB_RD_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    rob_param_if.slave    bus
);

    localparam int TAG_W = $clog2(DEPTH);
    localparam int CW    = TAG_W + 1;

    typedef struct packed {
        op_t             op;
        logic [RD_W-1:0] rd;
    } rob_entry_t;

    rob_entry_t       entries_r [DEPTH];
    logic [DEPTH-1:0] alloc_r;
    logic [DEPTH-1:0] done_r;
    logic [TAG_W-1:0] head_r;
    logic [TAG_W-1:0] tail_r;
    logic [CW-1:0]    count_r;
    rob_state_t       state_r;
    logic [DEPTH-1:0] flush_mask_r;

    logic [DEPTH-1:0] alloc_n_s;
    logic [DEPTH-1:0] done_n_s;
    logic [TAG_W-1:0] head_n_s;
    logic [TAG_W-1:0] tail_n_s;
    logic [CW-1:0]    count_n_s;
    rob_state_t       state_n_s;

    logic             disp_ready_s;
    logic             commit_valid_s;
    logic             commit_fire_s;
    logic             disp_fire_s;
    logic             br_run_s;
    logic             mispredict_s;
    logic [TAG_W-1:0] br_age_s;
    logic [DEPTH-1:0] age_mask_s;
    logic [DEPTH-1:0] squash_s;

    rob_age_mask #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_age_mask (
        .head   (head_r),
        .br_tag (bus.br_tag),
        .mask   (age_mask_s)
    );

    // Handshake qualifiers and squash set for the current cycle
    always_comb begin
        disp_ready_s   = (count_r < CW'(DEPTH)) && (state_r == RUN);
        commit_valid_s = alloc_r[head_r] && done_r[head_r] && (state_r == RUN);
        commit_fire_s  = commit_valid_s && bus.commit_ready;
        // Resolves arriving during FLUSH are ignored; unallocated tags are too
        br_run_s       = bus.br_valid && (state_r == RUN) && alloc_r[bus.br_tag];
        mispredict_s   = br_run_s && bus.br_mispredict;
        br_age_s       = bus.br_tag - head_r;
        if (mispredict_s) begin
            squash_s = age_mask_s & alloc_r;
        end else begin
            squash_s = '0;
        end
        // A mispredict wins over dispatch: the new op would be on the wrong path
        disp_fire_s    = bus.disp_valid && disp_ready_s && !mispredict_s;
    end

    // Next values of the alloc/done vectors, pointers and occupancy
    always_comb begin
        alloc_n_s = alloc_r;
        done_n_s  = done_r;

        // Completions: only allocated, non-squashed entries; duplicates just OR
        for (int i = 0; i < CDB_PORTS; i++) begin
            done_n_s[bus.cdb_tag[i*TAG_W +: TAG_W]] =
                done_n_s[bus.cdb_tag[i*TAG_W +: TAG_W]] |
                (bus.cdb_valid[i] &
                 alloc_r[bus.cdb_tag[i*TAG_W +: TAG_W]] &
                 ~squash_s[bus.cdb_tag[i*TAG_W +: TAG_W]]);
        end

        // Any resolved branch (right or wrong) is itself finished and retained
        done_n_s[bus.br_tag] = done_n_s[bus.br_tag] | br_run_s;

        alloc_n_s = alloc_n_s & ~squash_s;
        done_n_s  = done_n_s  & ~squash_s;

        alloc_n_s[head_r] = alloc_n_s[head_r] & ~commit_fire_s;
        done_n_s[head_r]  = done_n_s[head_r]  & ~commit_fire_s;

        // Tail is never allocated, so nothing above touched it this cycle
        alloc_n_s[tail_r] = alloc_n_s[tail_r] | disp_fire_s;
        done_n_s[tail_r]  = done_n_s[tail_r]  & ~disp_fire_s;

        if (commit_fire_s) begin
            head_n_s = head_r + TAG_W'(1);
        end else begin
            head_n_s = head_r;
        end

        if (mispredict_s) begin
            tail_n_s  = bus.br_tag + TAG_W'(1);
            // Survivors are head..branch inclusive, less a same-cycle commit
            count_n_s = CW'(br_age_s) + CW'(1) - (commit_fire_s ? CW'(1) : CW'(0));
        end else if (disp_fire_s) begin
            tail_n_s  = tail_r + TAG_W'(1);
            count_n_s = count_r + CW'(1) - (commit_fire_s ? CW'(1) : CW'(0));
        end else begin
            tail_n_s  = tail_r;
            count_n_s = count_r - (commit_fire_s ? CW'(1) : CW'(0));
        end
    end

    // FSM next state: a squash holds the ROB in FLUSH for exactly one cycle
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            RUN: begin
                if (mispredict_s) begin
                    state_n_s = FLUSH;
                end else begin
                    state_n_s = RUN;
                end
            end
            FLUSH:   state_n_s = RUN;
            default: state_n_s = RUN;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= RUN;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Bookkeeping registers and the registered squash mask
    always_ff @(posedge clk) begin
        if (!rst) begin
            alloc_r      <= '0;
            done_r       <= '0;
            head_r       <= '0;
            tail_r       <= '0;
            count_r      <= '0;
            flush_mask_r <= '0;
        end else begin
            alloc_r      <= alloc_n_s;
            done_r       <= done_n_s;
            head_r       <= head_n_s;
            tail_r       <= tail_n_s;
            count_r      <= count_n_s;
            flush_mask_r <= squash_s;
        end
    end

    // Entry payload storage, written on dispatch
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= '0;
            end
        end else if (disp_fire_s) begin
            entries_r[tail_r] <= '{op: bus.disp_op, rd: bus.disp_rd};
        end
    end

    assign bus.disp_ready   = disp_ready_s;
    assign bus.disp_tag     = tail_r;
    assign bus.commit_valid = commit_valid_s;
    assign bus.commit_op    = entries_r[head_r].op;
    assign bus.commit_rd    = entries_r[head_r].rd;
    assign bus.commit_tag   = head_r;
    assign bus.flush        = (state_r == FLUSH);
    assign bus.ld_pc        = (state_r == FLUSH);
    assign bus.flush_mask   = flush_mask_r;
    assign bus.rob_empty    = (count_r == CW'(0));
    assign bus.entry_done   = done_r;

endmodule

// File: tb/tb_rob_param.sv
// Directed bench for rob_param (DEPTH=8, CDB_PORTS=2, RD_W=5). Dispatches
// push the expected commit record onto a queue; a negedge monitor pops and
// compares whenever the DUT commits. Status outputs are checked directly
// against hand-computed values.
module tb_rob_param;
    import rob_param_pkg::*;

    localparam int DEPTH     = 8;
    localparam int CDB_PORTS = 2;
    localparam int RD_W      = 5;
    localparam int TAG_W     = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rob_param_if #(.DEPTH(DEPTH), .CDB_PORTS(CDB_PORTS), .RD_W(RD_W)) bus ();

    rob_param #(.DEPTH(DEPTH), .CDB_PORTS(CDB_PORTS), .RD_W(RD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [TAG_W-1:0] tag;
        op_t              op;
        logic [RD_W-1:0]  rd;
    } exp_t;

    exp_t             exp_q[$];
    int               errors    = 0;
    int               checks    = 0;
    int               n_commits = 0;
    logic [TAG_W-1:0] tb_tail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.disp_valid    = 1'b0;
        bus.disp_op       = OP_ALU;
        bus.disp_rd       = 5'd0;
        bus.cdb_valid     = 2'b00;
        bus.cdb_tag       = 6'd0;
        bus.br_valid      = 1'b0;
        bus.br_tag        = 3'd0;
        bus.br_mispredict = 1'b0;
        bus.commit_ready  = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic dispatch(input op_t op, input logic [RD_W-1:0] rd);
        exp_t e;
        chk("disp_ready_on_dispatch", bus.disp_ready, 1'b1);
        chk("disp_tag", bus.disp_tag, tb_tail);
        bus.disp_valid = 1'b1;
        bus.disp_op    = op;
        bus.disp_rd    = rd;
        e.tag = tb_tail;
        e.op  = op;
        e.rd  = rd;
        exp_q.push_back(e);
        tb_tail = tb_tail + 3'd1;
    endtask

    task automatic cdb(input int port, input logic [TAG_W-1:0] tag);
        bus.cdb_valid[port]               = 1'b1;
        bus.cdb_tag[port*TAG_W +: TAG_W]  = tag;
    endtask

    // Commit monitor: compare the head record with the oldest expected one
    always @(negedge clk) begin
        if (rst && bus.commit_valid && bus.commit_ready) begin
            n_commits++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit: got tag %0d expected none", bus.commit_tag);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("commit_tag", bus.commit_tag, e.tag);
                chk("commit_op", bus.commit_op, e.op);
                chk("commit_rd", bus.commit_rd, e.rd);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        tb_tail = 3'd0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset state
        chk("rst_disp_ready", bus.disp_ready, 1'b1);
        chk("rst_commit_valid", bus.commit_valid, 1'b0);
        chk("rst_flush", bus.flush, 1'b0);
        chk("rst_flush_mask", bus.flush_mask, 8'h00);
        chk("rst_ld_pc", bus.ld_pc, 1'b0);
        chk("rst_empty", bus.rob_empty, 1'b1);
        chk("rst_entry_done", bus.entry_done, 8'h00);

        // Fill: tags 0..7, then full
        for (int i = 0; i < 8; i++) begin
            dispatch(OP_ALU, 5'(i + 1));
            cyc();
        end
        chk("fill_disp_ready", bus.disp_ready, 1'b0);
        chk("fill_empty", bus.rob_empty, 1'b0);
        chk("fill_commit_valid", bus.commit_valid, 1'b0);
        bus.disp_valid = 1'b1;
        bus.disp_rd    = 5'd31;
        cyc();
        chk("full_disp_ready", bus.disp_ready, 1'b0);

        // Out-of-order completion 2,0,1 then in-order commit
        cdb(0, 3'd2); cyc();
        chk("ooo_done_a", bus.entry_done, 8'h04);
        chk("ooo_no_commit", bus.commit_valid, 1'b0);
        cdb(0, 3'd0); cyc();
        chk("ooo_done_b", bus.entry_done, 8'h05);
        chk("ooo_commit_valid", bus.commit_valid, 1'b1);
        chk("ooo_commit_tag", bus.commit_tag, 3'd0);
        cdb(1, 3'd1); cyc();
        chk("ooo_done_c", bus.entry_done, 8'h07);
        for (int i = 0; i < 3; i++) begin
            bus.commit_ready = 1'b1;
            cyc();
            chk("ooo_commit_count", n_commits, i + 1);
        end
        chk("ooo_stall", bus.commit_valid, 1'b0);
        chk("ooo_disp_ready", bus.disp_ready, 1'b1);
        chk("ooo_done_clear", bus.entry_done, 8'h00);

        // Duplicate tag on both ports, then drain
        cdb(0, 3'd3); cdb(1, 3'd3); cyc();
        chk("dup_done", bus.entry_done, 8'h08);
        cdb(0, 3'd4); cdb(1, 3'd5); cyc();
        cdb(0, 3'd6); cdb(1, 3'd7); cyc();
        chk("drain_done", bus.entry_done, 8'hF8);
        repeat (5) begin
            bus.commit_ready = 1'b1;
            cyc();
        end
        chk("drain_empty", bus.rob_empty, 1'b1);
        chk("drain_commits", n_commits, 8);

        // Move head/tail to 6
        for (int i = 0; i < 6; i++) begin
            dispatch(OP_ALU, 5'(10 + i));
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            cdb(0, 3'(2 * i)); cdb(1, 3'(2 * i + 1)); cyc();
        end
        repeat (6) begin
            bus.commit_ready = 1'b1;
            cyc();
        end
        chk("to6_empty", bus.rob_empty, 1'b1);
        chk("to6_commits", n_commits, 14);

        // Wrap: steady dispatch + commit, tags 6,7,0,1
        dispatch(OP_ALU, 5'd20); cyc();
        dispatch(OP_LD, 5'd21); cdb(0, 3'd6); cyc();
        dispatch(OP_ALU, 5'd22); cdb(0, 3'd7); bus.commit_ready = 1'b1; cyc();
        chk("wrap_empty_a", bus.rob_empty, 1'b0);
        chk("wrap_ready_a", bus.disp_ready, 1'b1);
        dispatch(OP_ST, 5'd23); cdb(0, 3'd0); bus.commit_ready = 1'b1; cyc();
        chk("wrap_empty_b", bus.rob_empty, 1'b0);
        chk("wrap_ready_b", bus.disp_ready, 1'b1);
        chk("wrap_done", bus.entry_done, 8'h01);
        chk("wrap_commits", n_commits, 16);
        cdb(0, 3'd1); bus.commit_ready = 1'b1; cyc();
        bus.commit_ready = 1'b1; cyc();
        chk("wrap_drain_empty", bus.rob_empty, 1'b1);
        chk("wrap_drain_commits", n_commits, 18);

        // Move head/tail to 5
        for (int i = 0; i < 3; i++) begin
            dispatch(OP_ALU, 5'(24 + i));
            cyc();
        end
        cdb(0, 3'd2); cdb(1, 3'd3); cyc();
        cdb(0, 3'd4); cyc();
        repeat (3) begin
            bus.commit_ready = 1'b1;
            cyc();
        end
        chk("to5_commits", n_commits, 21);

        // Mispredict mid-window: entries 5..2, branch at 7
        dispatch(OP_ALU, 5'd1); cyc();
        dispatch(OP_LD, 5'd2); cyc();
        dispatch(OP_BRANCH, 5'd3); cyc();
        dispatch(OP_ALU, 5'd4); cyc();
        dispatch(OP_ST, 5'd5); cyc();
        dispatch(OP_ALU, 5'd6); cyc();
        bus.br_valid = 1'b1; bus.br_tag = 3'd7; bus.br_mispredict = 1'b1;
        cyc();
        repeat (3) void'(exp_q.pop_back());
        tb_tail = 3'd0;
        chk("mp_flush", bus.flush, 1'b1);
        chk("mp_ld_pc", bus.ld_pc, 1'b1);
        chk("mp_flush_mask", bus.flush_mask, 8'h07);
        chk("mp_disp_ready", bus.disp_ready, 1'b0);
        chk("mp_commit_valid", bus.commit_valid, 1'b0);
        chk("mp_done", bus.entry_done, 8'h80);
        bus.disp_valid = 1'b1; bus.disp_rd = 5'd30;
        cdb(0, 3'd5);
        cyc();
        chk("post_flush", bus.flush, 1'b0);
        chk("post_ld_pc", bus.ld_pc, 1'b0);
        chk("post_flush_mask", bus.flush_mask, 8'h00);
        chk("post_disp_ready", bus.disp_ready, 1'b1);
        chk("post_done", bus.entry_done, 8'hA0);
        chk("post_commit_tag", bus.commit_tag, 3'd5);
        // Three survivors: exactly five more slots
        for (int i = 0; i < 5; i++) begin
            dispatch(OP_ALU, 5'(7 + i));
            cyc();
        end
        chk("post_full", bus.disp_ready, 1'b0);
        cdb(0, 3'd6); cdb(1, 3'd0); cyc();
        cdb(0, 3'd1); cdb(1, 3'd2); cyc();
        cdb(0, 3'd3); cdb(1, 3'd4); cyc();
        repeat (8) begin
            bus.commit_ready = 1'b1;
            cyc();
        end
        chk("mp_drain_empty", bus.rob_empty, 1'b1);
        chk("mp_drain_commits", n_commits, 29);

        // Move head/tail to 0
        for (int i = 0; i < 3; i++) begin
            dispatch(OP_ALU, 5'(12 + i));
            cyc();
        end
        cdb(0, 3'd5); cdb(1, 3'd6); cyc();
        cdb(0, 3'd7); cyc();
        repeat (3) begin
            bus.commit_ready = 1'b1;
            cyc();
        end
        chk("to0_commits", n_commits, 32);

        // Simultaneous mispredict + commit + dispatch + CDB to squashed tag
        dispatch(OP_ALU, 5'd1); cyc();
        dispatch(OP_BRANCH, 5'd2); cyc();
        dispatch(OP_ALU, 5'd3); cyc();
        dispatch(OP_ALU, 5'd4); cyc();
        cdb(0, 3'd0); cyc();
        chk("sim_commit_valid", bus.commit_valid, 1'b1);
        bus.br_valid = 1'b1; bus.br_tag = 3'd1; bus.br_mispredict = 1'b1;
        bus.commit_ready = 1'b1;
        bus.disp_valid = 1'b1; bus.disp_rd = 5'd9;
        cdb(0, 3'd3);
        cyc();
        repeat (2) void'(exp_q.pop_back());
        tb_tail = 3'd2;
        chk("sim_commits", n_commits, 33);
        chk("sim_flush", bus.flush, 1'b1);
        chk("sim_flush_mask", bus.flush_mask, 8'h0C);
        chk("sim_done", bus.entry_done, 8'h02);
        cyc();
        chk("sim_post_flush", bus.flush, 1'b0);
        chk("sim_commit_tag", bus.commit_tag, 3'd1);
        chk("sim_commit_valid_b", bus.commit_valid, 1'b1);
        chk("sim_disp_tag", bus.disp_tag, 3'd2);
        bus.commit_ready = 1'b1; cyc();
        chk("sim_empty", bus.rob_empty, 1'b1);
        chk("sim_commits_b", n_commits, 34);

        // Correct prediction marks done only; then mispredict and reset in FLUSH
        dispatch(OP_BRANCH, 5'd5); cyc();
        dispatch(OP_ALU, 5'd6); cyc();
        dispatch(OP_ALU, 5'd7); cyc();
        bus.br_valid = 1'b1; bus.br_tag = 3'd2; bus.br_mispredict = 1'b0;
        cyc();
        chk("ok_br_flush", bus.flush, 1'b0);
        chk("ok_br_done", bus.entry_done, 8'h04);
        chk("ok_br_ready", bus.disp_ready, 1'b1);
        bus.br_valid = 1'b1; bus.br_tag = 3'd2; bus.br_mispredict = 1'b1;
        cyc();
        chk("rf_flush", bus.flush, 1'b1);
        chk("rf_flush_mask", bus.flush_mask, 8'h18);
        rst = 1'b0;
        cyc();
        chk("rf_flush_off", bus.flush, 1'b0);
        chk("rf_ld_pc_off", bus.ld_pc, 1'b0);
        chk("rf_mask_off", bus.flush_mask, 8'h00);
        chk("rf_empty", bus.rob_empty, 1'b1);
        chk("rf_disp_ready", bus.disp_ready, 1'b1);
        chk("rf_commit_valid", bus.commit_valid, 1'b0);
        chk("rf_done", bus.entry_done, 8'h00);
        rst = 1'b1;
        exp_q.delete();
        tb_tail = 3'd0;

        // Normal operation after reset
        dispatch(OP_LD, 5'd12); cyc();
        cdb(1, 3'd0); cyc();
        bus.commit_ready = 1'b1; cyc();
        chk("final_commits", n_commits, 35);
        chk("final_empty", bus.rob_empty, 1'b1);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
